// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer: FSM states,
// cause codes and the default vector base address.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SAVE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] EXC_INVOP = 2'd0;
  localparam logic [1:0] EXC_OVF   = 2'd1;
  localparam logic [1:0] EXC_DIV0  = 2'd2;
  localparam logic [1:0] EXC_NONE  = 2'd3;

  localparam int unsigned VEC_BASE_DEFAULT = 32'd253;

  // Fixed cause priority: invalid opcode beats overflow beats divide-by-zero.
  function automatic logic [1:0] pick_cause(input logic invalid_op,
                                            input logic overflow,
                                            input logic div0);
    logic [1:0] cause;
    if (invalid_op) begin
      cause = EXC_INVOP;
    end else if (overflow) begin
      cause = EXC_OVF;
    end else if (div0) begin
      cause = EXC_DIV0;
    end else begin
      cause = EXC_NONE;
    end
    return cause;
  endfunction

endpackage

// File: rtl/exc_wait_cnt.sv
// 3-bit down counter with synchronous load and a zero flag; times the
// memory-read dwell of the exception sequencer.
module exc_wait_cnt (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [2:0] count_r;

  // Load takes precedence over decrement; the count saturates at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= 3'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != 3'd0)) begin
      count_r <= count_r - 3'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 3'd0);

endmodule

// File: rtl/exception_unit.sv
// Exception sequencer: on a checked fault it writes EPC, fetches the handler
// byte from the vector table and loads it into PC under a busy/done handshake.
module exception_unit
  import exc_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 32'd2,
  parameter int unsigned VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        check_en,
  input  logic        invalid_op,
  input  logic        overflow,
  input  logic        div0,
  input  logic [31:0] pc_in,
  input  logic [7:0]  mem_byte_in,
  output logic        busy,
  output logic        done,
  output logic [1:0]  exc_code,
  output logic        mem_addr_sel,
  output logic [31:0] mem_addr,
  output logic        epc_we,
  output logic [31:0] epc_value,
  output logic        pc_we,
  output logic [31:0] pc_value
);

  localparam logic [2:0]  LAT_LOAD = 3'(MEM_LAT - 32'd1);
  localparam logic [31:0] VEC_ADDR = 32'(VEC_BASE);

  state_t      state_r;
  state_t      state_s;
  logic [1:0]  cause_r;
  logic [31:0] pc_cap_r;
  logic [7:0]  vec_r;
  logic        trigger_s;
  logic        cnt_load_s;
  logic        cnt_dec_s;
  logic        cnt_zero_s;

  assign trigger_s = check_en & (invalid_op | overflow | div0);

  exc_wait_cnt u_wait_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Cause, captured PC and fetched vector byte; only the trigger and the
  // final FETCH cycle update them, so exc_code holds between sequences.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cause_r  <= EXC_NONE;
      pc_cap_r <= 32'd0;
      vec_r    <= 8'd0;
    end else begin
      if ((state_r == ST_IDLE) && trigger_s) begin
        cause_r  <= pick_cause(invalid_op, overflow, div0);
        pc_cap_r <= pc_in;
      end else begin
        cause_r  <= cause_r;
        pc_cap_r <= pc_cap_r;
      end
      if ((state_r == ST_FETCH) && cnt_zero_s) begin
        vec_r <= mem_byte_in;
      end else begin
        vec_r <= vec_r;
      end
    end
  end

  // Next-state logic and dwell-counter control.
  always_comb begin
    state_s    = state_r;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trigger_s) begin
          state_s = ST_SAVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SAVE: begin
        cnt_load_s = 1'b1;
        state_s    = ST_FETCH;
      end
      ST_FETCH: begin
        cnt_dec_s = 1'b1;
        if (cnt_zero_s) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_LOAD: state_s = ST_DONE;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only; values read 0 outside
  // the state that owns them.
  always_comb begin
    busy         = 1'b1;
    done         = 1'b0;
    exc_code     = cause_r;
    mem_addr_sel = 1'b0;
    mem_addr     = 32'd0;
    epc_we       = 1'b0;
    epc_value    = 32'd0;
    pc_we        = 1'b0;
    pc_value     = 32'd0;
    case (state_r)
      ST_IDLE: busy = 1'b0;
      ST_SAVE: begin
        epc_we    = 1'b1;
        epc_value = pc_cap_r - 32'd4;
      end
      ST_FETCH: begin
        mem_addr_sel = 1'b1;
        mem_addr     = VEC_ADDR + {30'd0, cause_r};
      end
      ST_LOAD: begin
        pc_we    = 1'b1;
        pc_value = {24'd0, vec_r};
      end
      ST_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exception_unit.sv
// Directed, table-driven bench for exception_unit with MEM_LAT=2 and a
// second MEM_LAT=1 instance for the latency/wrap case.
module tb_exception_unit;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        check_en, invalid_op, overflow, div0;
  logic [31:0] pc_in;
  logic [7:0]  mem_byte0, mem_byte1;

  logic        busy0, done0, sel0, epc_we0, pc_we0;
  logic [1:0]  code0;
  logic [31:0] addr0, epc_val0, pc_val0;
  logic        busy1, done1, sel1, epc_we1, pc_we1;
  logic [1:0]  code1;
  logic [31:0] addr1, epc_val1, pc_val1;

  logic [7:0]  mem [0:255];
  int          age0 = 0;
  int          age1 = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  exception_unit #(.MEM_LAT(LAT0), .VEC_BASE(253)) dut0 (
    .clock(clock), .reset(reset), .check_en(check_en), .invalid_op(invalid_op),
    .overflow(overflow), .div0(div0), .pc_in(pc_in), .mem_byte_in(mem_byte0),
    .busy(busy0), .done(done0), .exc_code(code0), .mem_addr_sel(sel0),
    .mem_addr(addr0), .epc_we(epc_we0), .epc_value(epc_val0),
    .pc_we(pc_we0), .pc_value(pc_val0));

  exception_unit #(.MEM_LAT(LAT1), .VEC_BASE(253)) dut1 (
    .clock(clock), .reset(reset), .check_en(check_en), .invalid_op(invalid_op),
    .overflow(overflow), .div0(div0), .pc_in(pc_in), .mem_byte_in(mem_byte1),
    .busy(busy1), .done(done1), .exc_code(code1), .mem_addr_sel(sel1),
    .mem_addr(addr1), .epc_we(epc_we1), .epc_value(epc_val1),
    .pc_we(pc_we1), .pc_value(pc_val1));

  // Memory model: read data is garbage until the address has been held
  // for the full latency.
  always @(posedge clock) begin
    age0 <= sel0 ? age0 + 1 : 0;
    age1 <= sel1 ? age1 + 1 : 0;
  end
  assign mem_byte0 = (sel0 && age0 >= LAT0 - 1) ? mem[addr0[7:0]] : 8'hEE;
  assign mem_byte1 = (sel1 && age1 >= LAT1 - 1) ? mem[addr1[7:0]] : 8'hEE;

  typedef struct {
    logic        inv;
    logic        ovf;
    logic        d0;
    logic        noise;
    logic [31:0] pc;
    logic [1:0]  code;
    logic [31:0] addr;
    logic [7:0]  vec;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    check_en = 1'b0; invalid_op = 1'b0; overflow = 1'b0; div0 = 1'b0;
  endtask

  // One full MEM_LAT=2 sequence on dut0, checked cycle by cycle.
  task automatic run_seq(input vec_t v);
    @(negedge clock);
    check("idle_busy", {31'd0, busy0}, 32'd0);
    check_en = 1'b1; invalid_op = v.inv; overflow = v.ovf; div0 = v.d0; pc_in = v.pc;
    @(negedge clock);
    clear_inputs(); pc_in = 32'hDEADBEEF;
    check("save_busy", {31'd0, busy0}, 32'd1);
    check("save_epc_we", {31'd0, epc_we0}, 32'd1);
    check("save_epc_value", epc_val0, v.pc - 32'd4);
    check("save_sel", {31'd0, sel0}, 32'd0);
    check("save_code", {30'd0, code0}, {30'd0, v.code});
    for (int c = 2; c <= 3; c++) begin
      @(negedge clock);
      check_en = v.noise; div0 = v.noise;
      check("fetch_sel", {31'd0, sel0}, 32'd1);
      check("fetch_addr", addr0, v.addr);
      check("fetch_epc", {31'd0, epc_we0} | epc_val0, 32'd0);
      check("fetch_pc_we", {31'd0, pc_we0}, 32'd0);
    end
    @(negedge clock);
    clear_inputs();
    check("load_pc_we", {31'd0, pc_we0}, 32'd1);
    check("load_pc_value", pc_val0, {24'd0, v.vec});
    check("load_addr", {31'd0, sel0} | addr0, 32'd0);
    check("load_done", {31'd0, done0}, 32'd0);
    @(negedge clock);
    check("done_pulse", {31'd0, done0}, 32'd1);
    check("done_busy", {31'd0, busy0}, 32'd1);
    check("done_pc", {31'd0, pc_we0} | pc_val0, 32'd0);
    @(negedge clock);
    check("after_done", {30'd0, busy0, done0}, 32'd0);
    check("code_hold", {30'd0, code0}, {30'd0, v.code});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[253] = 8'h80; mem[254] = 8'h40; mem[255] = 8'hC3;

    tbl[0] = '{inv: 1'b1, ovf: 1'b0, d0: 1'b0, noise: 1'b0, pc: 32'h0000_0104,
               code: 2'd0, addr: 32'd253, vec: 8'h80};
    tbl[1] = '{inv: 1'b0, ovf: 1'b1, d0: 1'b1, noise: 1'b0, pc: 32'h0000_2000,
               code: 2'd1, addr: 32'd254, vec: 8'h40};
    tbl[2] = '{inv: 1'b0, ovf: 1'b0, d0: 1'b1, noise: 1'b0, pc: 32'h0000_0008,
               code: 2'd2, addr: 32'd255, vec: 8'hC3};
    tbl[3] = '{inv: 1'b1, ovf: 1'b1, d0: 1'b1, noise: 1'b1, pc: 32'h0040_0010,
               code: 2'd0, addr: 32'd253, vec: 8'h80};

    reset = 1'b1; clear_inputs(); pc_in = 32'd0;
    @(negedge clock);
    check("rst_code", {30'd0, code0}, 32'd3);
    check("rst_outs", {28'd0, busy0, done0, sel0, epc_we0} | {31'd0, pc_we0}, 32'd0);
    check("rst_vals", addr0 | epc_val0 | pc_val0, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_seq(tbl[i]);

    // Flags with the check window closed must never start a sequence.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("closed_busy", {31'd0, busy0}, 32'd0);
      check("closed_we", {30'd0, epc_we0, pc_we0}, 32'd0);
      check("closed_code", {30'd0, code0}, 32'd0);
      check_en = 1'b0; invalid_op = 1'b1; overflow = 1'b1; div0 = 1'b1;
      pc_in = 32'(i) * 32'd16;
    end
    @(negedge clock);
    check("closed_busy_end", {31'd0, busy0}, 32'd0);
    clear_inputs();

    // Reset asserted during FETCH clears everything immediately.
    @(negedge clock);
    check_en = 1'b1; invalid_op = 1'b1; pc_in = 32'h0000_0300;
    @(negedge clock);
    clear_inputs();
    @(negedge clock);
    check("pre_rst_sel", {31'd0, sel0}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_code", {30'd0, code0}, 32'd3);
    check("midrst_outs", {27'd0, busy0, done0, sel0, epc_we0, pc_we0}, 32'd0);
    check("midrst_vals", addr0 | epc_val0 | pc_val0, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("postrst_quiet", {30'd0, busy0, pc_we0}, 32'd0);
    end
    run_seq('{inv: 1'b0, ovf: 1'b1, d0: 1'b0, noise: 1'b0, pc: 32'h0000_1000,
              code: 2'd1, addr: 32'd254, vec: 8'h40});

    // PC wrap and MEM_LAT=1 timing on dut1.
    @(negedge clock);
    check_en = 1'b1; invalid_op = 1'b1; pc_in = 32'h0000_0000;
    @(negedge clock);
    clear_inputs();
    check("wrap_epc_we", {31'd0, epc_we1}, 32'd1);
    check("wrap_epc1", epc_val1, 32'hFFFF_FFFC);
    check("wrap_epc0", epc_val0, 32'hFFFF_FFFC);
    @(negedge clock);
    check("lat1_fetch", {31'd0, sel1}, 32'd1);
    check("lat1_addr", addr1, 32'd253);
    @(negedge clock);
    check("lat1_load", {31'd0, pc_we1}, 32'd1);
    check("lat1_pc", pc_val1, 32'h0000_0080);
    check("lat1_nodone", {31'd0, done1}, 32'd0);
    @(negedge clock);
    check("lat1_done", {31'd0, done1}, 32'd1);
    @(negedge clock);
    check("lat1_idle", {30'd0, busy1, done1}, 32'd0);
    check("lat0_done", {31'd0, done0}, 32'd1);
    @(negedge clock);
    check("lat0_idle", {31'd0, busy0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
